// File: rtl/gshare_predictor.sv
// gshare branch predictor: 2-bit counter PHT indexed by PC[INDEX_W+1:2] ^ GHR, swept to weakly-not-taken after reset.
// Latency: prediction registered, valid one cycle after request; updates land on the next edge.
// Backpressure: none; o_ready low during the init sweep, requests/updates dropped then. Option: GSHARE_PREDICTOR_BYPASS_EN.
module gshare_predictor #(
   parameter int PC_W    = 32,
   parameter int INDEX_W = 6,
   parameter int GHR_W   = 6
) (
   input  logic               i_clk,
   input  logic               i_rst,
   output logic               o_ready,
   input  logic               i_pred_valid,
   input  logic [PC_W-1:0]    i_pred_pc,
   output logic               o_pred_valid,
   output logic               o_pred_taken,
   output logic [INDEX_W-1:0] o_pred_index,
   output logic [GHR_W-1:0]   o_pred_ghr,
   input  logic               i_upd_valid,
   input  logic [INDEX_W-1:0] i_upd_index,
   input  logic               i_upd_taken,
   input  logic               i_upd_mispredict,
   input  logic [GHR_W-1:0]   i_upd_ghr
);

   localparam int ENTRIES = 1 << INDEX_W;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [INDEX_W-1:0] ptr_q, ptr_d;
   logic [GHR_W-1:0]   ghr_q, ghr_d;
   logic [1:0]         pht [ENTRIES];

   logic               init_we;
   logic               pred_acc;
   logic               upd_acc;
   logic [INDEX_W-1:0] pred_idx;
   logic [1:0]         pred_cnt;
   logic [1:0]         upd_cnt_next;
   logic               pred_bit;

   // PC bits below the word offset and above the index, and the oldest
   // snapshot bit, have no role in indexing or repair.
   logic unused_bits;
   assign unused_bits = ^{i_pred_pc[PC_W-1:INDEX_W+2], i_pred_pc[1:0], i_upd_ghr[GHR_W-1]};

   // Saturating step: up on taken, down on not-taken.
   function automatic logic [1:0] cnt_step(input logic [1:0] c, input logic taken);
      logic [1:0] r;
      r = c;
      if (taken) begin
         if (c != 2'b11) r = c + 2'b01;
      end else begin
         if (c != 2'b00) r = c - 2'b01;
      end
      return r;
   endfunction

   assign o_ready = (state_q == ST_RUN);

   // Sweep/run sequencing: INIT writes one entry per cycle, RUN accepts traffic.
   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      init_we  = 1'b0;
      pred_acc = 1'b0;
      upd_acc  = 1'b0;
      case (state_q)
         ST_INIT: begin
            init_we = 1'b1;
            ptr_d   = ptr_q + 1'b1;
            if (ptr_q == {INDEX_W{1'b1}}) state_d = ST_RUN;
         end
         ST_RUN: begin
            pred_acc = i_pred_valid;
            upd_acc  = i_upd_valid;
         end
         default: state_d = ST_INIT;
      endcase
   end

   // Index hash, counter lookup (with optional same-index forwarding) and next GHR.
   always_comb begin
      pred_idx     = i_pred_pc[INDEX_W+1:2] ^ INDEX_W'(ghr_q);
      pred_cnt     = pht[pred_idx];
      upd_cnt_next = cnt_step(pht[i_upd_index], i_upd_taken);
`ifdef GSHARE_PREDICTOR_BYPASS_EN
      if (upd_acc && (i_upd_index == pred_idx)) pred_cnt = upd_cnt_next;
`endif
      pred_bit = pred_cnt[1];
      ghr_d    = ghr_q;
      // Repair wins over the speculative shift of a same-cycle prediction.
      if (upd_acc && i_upd_mispredict) begin
         ghr_d = {i_upd_ghr[GHR_W-2:0], i_upd_taken};
      end else if (pred_acc) begin
         ghr_d = {ghr_q[GHR_W-2:0], pred_bit};
      end
   end

   // Control state, history and registered prediction outputs.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q      <= ST_INIT;
         ptr_q        <= '0;
         ghr_q        <= '0;
         o_pred_valid <= 1'b0;
         o_pred_taken <= 1'b0;
         o_pred_index <= '0;
         o_pred_ghr   <= '0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         ghr_q        <= ghr_d;
         o_pred_valid <= pred_acc;
         if (pred_acc) begin
            o_pred_taken <= pred_bit;
            o_pred_index <= pred_idx;
            o_pred_ghr   <= ghr_q;
         end
      end
   end

   // PHT storage: sweep writes during INIT, counter updates during RUN.
   always_ff @(posedge i_clk) begin
      if (init_we) begin
         pht[ptr_q] <= 2'b01;
      end else if (upd_acc) begin
         pht[i_upd_index] <= upd_cnt_next;
      end
   end

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor (INDEX_W=4, GHR_W=4): directed scenarios plus random traffic.
// Latency: compares every negedge against a behavioural model advanced at each posedge.
// Backpressure: n/a; traffic is only expected to take effect once o_ready is high.
module tb_gshare_predictor;
   localparam int PC_W = 32;
   localparam int IW   = 4;
   localparam int GW   = 4;
   localparam int N    = 16;

   logic          i_clk;
   logic          i_rst;
   logic          o_ready;
   logic          i_pred_valid;
   logic [31:0]   i_pred_pc;
   logic          o_pred_valid;
   logic          o_pred_taken;
   logic [IW-1:0] o_pred_index;
   logic [GW-1:0] o_pred_ghr;
   logic          i_upd_valid;
   logic [IW-1:0] i_upd_index;
   logic          i_upd_taken;
   logic          i_upd_mispredict;
   logic [GW-1:0] i_upd_ghr;

   gshare_predictor #(.PC_W(PC_W), .INDEX_W(IW), .GHR_W(GW)) dut (
      .i_clk(i_clk), .i_rst(i_rst), .o_ready(o_ready),
      .i_pred_valid(i_pred_valid), .i_pred_pc(i_pred_pc),
      .o_pred_valid(o_pred_valid), .o_pred_taken(o_pred_taken),
      .o_pred_index(o_pred_index), .o_pred_ghr(o_pred_ghr),
      .i_upd_valid(i_upd_valid), .i_upd_index(i_upd_index),
      .i_upd_taken(i_upd_taken), .i_upd_mispredict(i_upd_mispredict),
      .i_upd_ghr(i_upd_ghr)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int n_checks = 0;
   int n_errors = 0;
   bit chk_en   = 0;

   // Model state: counters as plain integers 0..3, history as an integer.
   int pht_m [N];
   int ghr_m;
   int init_cnt;
   int exp_ready, exp_valid, exp_taken, exp_index, exp_ghr;

   task automatic check(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int sat(input int v);
      if (v < 0) return 0;
      if (v > 3) return 3;
      return v;
   endfunction

   task automatic model_reset();
      init_cnt  = 0;
      ghr_m     = 0;
      exp_ready = 0;
      exp_valid = 0;
      exp_taken = 0;
      exp_index = 0;
      exp_ghr   = 0;
      for (int i = 0; i < N; i++) pht_m[i] = 1;
   endtask

   // Advance the model by one clock using the inputs the DUT just sampled.
   task automatic model_step();
      int pidx, c, t, ng, ui;
      if (i_rst) return;
      if (init_cnt < N) begin
         init_cnt++;
         exp_valid = 0;
      end else begin
         pidx = int'(i_pred_pc[5:2]) ^ ghr_m;
         c    = pht_m[pidx];
         ui   = int'(i_upd_index);
`ifdef GSHARE_PREDICTOR_BYPASS_EN
         if (i_upd_valid && ui == pidx) c = sat(c + (i_upd_taken ? 1 : -1));
`endif
         t  = (c >= 2) ? 1 : 0;
         ng = ghr_m;
         if (i_pred_valid) begin
            exp_valid = 1;
            exp_taken = t;
            exp_index = pidx;
            exp_ghr   = ghr_m;
            ng        = (ghr_m * 2 + t) % 16;
         end else begin
            exp_valid = 0;
         end
         if (i_upd_valid) begin
            pht_m[ui] = sat(pht_m[ui] + (i_upd_taken ? 1 : -1));
            if (i_upd_mispredict) ng = (int'(i_upd_ghr) * 2 + int'(i_upd_taken)) % 16;
         end
         ghr_m = ng;
      end
      exp_ready = (init_cnt >= N) ? 1 : 0;
   endtask

   // Single compare process against the model.
   always @(negedge i_clk) begin
      if (chk_en) begin
         check("ready", int'(o_ready), exp_ready);
         check("pred_valid", int'(o_pred_valid), exp_valid);
         if (exp_valid != 0) begin
            check("pred_taken", int'(o_pred_taken), exp_taken);
            check("pred_index", int'(o_pred_index), exp_index);
            check("pred_ghr", int'(o_pred_ghr), exp_ghr);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic cycle();
      @(posedge i_clk);
      model_step();
      #1;
   endtask

   task automatic idle_inputs();
      i_pred_valid     = 0;
      i_pred_pc        = '0;
      i_upd_valid      = 0;
      i_upd_index      = '0;
      i_upd_taken      = 0;
      i_upd_mispredict = 0;
      i_upd_ghr        = '0;
   endtask

   function automatic logic [31:0] pc_for(input int idx);
      logic [31:0] p;
      p      = $urandom & 32'hFFFF_FFC3;
      p[5:2] = 4'(idx ^ ghr_m);
      return p;
   endfunction

   task automatic predict_idx(input int idx, input int exp_t, input string nm);
      i_pred_valid = 1;
      i_pred_pc    = pc_for(idx);
      cycle();
      i_pred_valid = 0;
      check(nm, int'(o_pred_taken), exp_t);
      check({nm, "_idx"}, int'(o_pred_index), idx);
   endtask

   task automatic upd(input int idx, input int t, input int mis, input int ughr);
      i_upd_valid      = 1;
      i_upd_index      = 4'(idx);
      i_upd_taken      = 1'(t);
      i_upd_mispredict = 1'(mis);
      i_upd_ghr        = 4'(ughr);
      cycle();
      idle_inputs();
   endtask

   // Count cycles with o_ready low after reset release; must be exactly the sweep length.
   task automatic count_sweep(input string nm);
      int n0;
      n0 = 0;
      while (!o_ready && n0 < 40) begin
         n0++;
         cycle();
      end
      check(nm, n0, N);
   endtask

   initial begin
      idle_inputs();
      i_rst = 1;
      model_reset();
      chk_en = 1;
      repeat (2) @(posedge i_clk);
      #1;
      check("rst_ready", int'(o_ready), 0);
      check("rst_valid", int'(o_pred_valid), 0);
      check("rst_taken", int'(o_pred_taken), 0);
      check("rst_index", int'(o_pred_index), 0);
      check("rst_ghr", int'(o_pred_ghr), 0);

      // Requests during the sweep must be ignored.
      i_rst        = 0;
      i_pred_valid = 1;
      i_pred_pc    = 32'h14;
      i_upd_valid  = 1;
      i_upd_index  = 4'd5;
      i_upd_taken  = 1;
      count_sweep("sweep_len");
      idle_inputs();

      // Every entry starts weakly not-taken (GHR stays 0 throughout).
      for (int i = 0; i < N; i++) predict_idx(i, 0, "init_entry");

      // Single-entry training on idx 5.
      upd(5, 1, 0, 0);
      predict_idx(5, 1, "idx5_t1");
      upd(5, 1, 0, 0);
      predict_idx(5, 1, "idx5_t2");
      upd(5, 0, 0, 0);
      predict_idx(5, 1, "idx5_nt");
      upd(5, 0, 0, 0);
      predict_idx(5, 0, "idx5_nt2");

      // Saturation high on idx 3.
      repeat (5) upd(3, 1, 0, 0);
      upd(3, 0, 0, 0);
      predict_idx(3, 1, "idx3_sat");
      upd(3, 0, 0, 0);
      predict_idx(3, 0, "idx3_down");

      // Saturation low on idx 9.
      repeat (4) upd(9, 0, 0, 0);
      upd(9, 1, 0, 0);
      predict_idx(9, 0, "idx9_floor");
      upd(9, 1, 0, 0);
      predict_idx(9, 1, "idx9_up");

      // History: clear via repair, three not-taken predictions, then repair to 0101.
      upd(15, 0, 1, 0);
      for (int k = 1; k <= 3; k++) begin
         i_pred_valid = 1;
         i_pred_pc    = 32'(k * 16);
         cycle();
         i_pred_valid = 0;
         check("ghr_zero", int'(o_pred_ghr), 0);
         check("ghr_zero_taken", int'(o_pred_taken), 0);
      end
      upd(15, 1, 1, 4'b0010);
      i_pred_valid = 1;
      i_pred_pc    = 32'h0;
      cycle();
      i_pred_valid = 0;
      check("repair_index", int'(o_pred_index), 5);
      check("repair_ghr", int'(o_pred_ghr), 5);

      // Same-cycle prediction and repair: history now 1010.
      i_pred_valid     = 1;
      i_pred_pc        = 32'h0;
      i_upd_valid      = 1;
      i_upd_index      = 4'd0;
      i_upd_taken      = 0;
      i_upd_mispredict = 1;
      i_upd_ghr        = 4'b0011;
      cycle();
      idle_inputs();
      check("simul_ghr", int'(o_pred_ghr), 10);
      check("simul_index", int'(o_pred_index), 10);
      i_pred_valid = 1;
      i_pred_pc    = 32'h0;
      cycle();
      i_pred_valid = 0;
      check("post_repair_index", int'(o_pred_index), 6);
      check("post_repair_ghr", int'(o_pred_ghr), 6);

      // Same-index update and prediction on idx 2 (counter at 01).
      i_pred_valid = 1;
      i_pred_pc    = pc_for(2);
      i_upd_valid  = 1;
      i_upd_index  = 4'd2;
      i_upd_taken  = 1;
      cycle();
      idle_inputs();
`ifdef GSHARE_PREDICTOR_BYPASS_EN
      check("same_idx", int'(o_pred_taken), 1);
`else
      check("same_idx", int'(o_pred_taken), 0);
`endif

      // Random traffic.
      for (int r = 0; r < 400; r++) begin
         i_pred_valid     = 1'($urandom_range(0, 1));
         i_pred_pc        = $urandom;
         i_upd_valid      = 1'($urandom_range(0, 1));
         i_upd_index      = 4'($urandom_range(0, 15));
         i_upd_taken      = 1'($urandom_range(0, 1));
         i_upd_mispredict = ($urandom_range(0, 3) == 0);
         i_upd_ghr        = 4'($urandom_range(0, 15));
         cycle();
      end
      idle_inputs();

      // Reset pulsed with the sweep pointer at 7.
      i_rst = 1;
      model_reset();
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 0;
      repeat (7) cycle();
      check("mid_ready_pre", int'(o_ready), 0);
      i_rst = 1;
      model_reset();
      #1;
      check("mid_ready", int'(o_ready), 0);
      check("mid_valid", int'(o_pred_valid), 0);
      repeat (2) @(posedge i_clk);
      #1;
      i_rst = 0;
      count_sweep("resweep_len");
      for (int r = 0; r < 60; r++) begin
         i_pred_valid     = 1'($urandom_range(0, 1));
         i_pred_pc        = $urandom;
         i_upd_valid      = 1'($urandom_range(0, 1));
         i_upd_index      = 4'($urandom_range(0, 15));
         i_upd_taken      = 1'($urandom_range(0, 1));
         i_upd_mispredict = 1'($urandom_range(0, 1));
         i_upd_ghr        = 4'($urandom_range(0, 15));
         cycle();
      end
      idle_inputs();
      cycle();
      @(negedge i_clk);
      #1;
      chk_en = 0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
